cdc_hs_rx: RTL

- Destination end of a 4-phase req/ack CDC handshake. Runs entirely in the destination clock domain.
- Takes an asynchronous request level plus a multi-bit data bus that the source holds stable. Synchronizes only the request, captures the data once, and presents it to local logic with valid/ready.
- Returns a registered, glitch-free acknowledge level to the source domain.
- Pairs with a source-side transmitter that raises req, holds data, waits for ack, then drops req.

---
 rtl/cdc_hs_pkg.sv | 14 +
 rtl/sync_nff.sv | 30 +++
 rtl/cdc_hs_rx.sv | 94 +++++++++
 3 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the req/ack CDC handshake pair.
// Used by both the receiver and the matching transmitter.
package cdc_hs_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t HOLD = 2'b01;
  localparam state_t ACK  = 2'b10;

  localparam int MIN_SYNC  = 2;
  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/sync_nff.sv
// N-stage single-bit level synchronizer.
// Async active-low reset clears every stage to 0.
module sync_nff
  import cdc_hs_pkg::*;
#(
  parameter int N = MIN_SYNC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  if (N < MIN_SYNC) begin : g_bad_depth
    $error("sync_nff: N must be >= 2");
  end

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination end of a 4-phase req/ack CDC handshake.
// Optional sticky protocol-error flag: define CDC_HS_RX_ERR_EN.
module cdc_hs_rx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             ack
`ifdef CDC_HS_RX_ERR_EN
  ,
  output logic             err
`endif
);

  if (SYNC_STAGES < MIN_SYNC) begin : g_bad_sync
    $error("cdc_hs_rx: SYNC_STAGES must be >= 2");
  end

  logic             req_s;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  sync_nff #(
    .N(SYNC_STAGES)
  ) u_req_sync (
    .clk  (clk),
    .rst_n(rst),
    .d_i  (req_async),
    .q_o  (req_s)
  );

  // data_async is only sampled once req_s proves the source holds it.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (req_s) begin
          dout_d  = data_async;
          state_d = HOLD;
        end
      end
      (state_q == HOLD): begin
        if (dout_ready) state_d = ACK;
      end
      (state_q == ACK): begin
        if (!req_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  // One-hot-ish encoding lets valid and ack come straight off state bits.
  assign dout       = dout_q;
  assign dout_valid = state_q[0];
  assign ack        = state_q[1];

`ifdef CDC_HS_RX_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | ((state_q == HOLD) & ~req_s);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule
